// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and counter sizing.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that must reach n-1; at least one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell: s/c_out = x + y + c_in.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    assign s     = x ^ y ^ c_in;
    assign c_out = (x & y) | (x & c_in) | (y & c_in);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full_adder cell plus carry flip-flop, LSB first,
// with a start/busy/done handshake.
module serial_adder
    import serial_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         c_out
);

    localparam int unsigned CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    state_t           state;
    logic [N-1:0]     a_sr;
    logic [N-1:0]     b_sr;
    logic [N-1:0]     s_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_s;
    logic             fa_c;
    logic             load;

    full_adder u_fa (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .c_in (carry),
        .s    (fa_s),
        .c_out(fa_c)
    );

    // New operands are accepted only from IDLE or DONE; start during CALC is ignored.
    assign load = start && (state == IDLE || state == DONE);

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
        end else if (load) begin
            state <= CALC;
            a_sr  <= a;
            b_sr  <= b;
            carry <= c_in;
            cnt   <= '0;
        end else begin
            unique case (state)
                CALC: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    s_sr  <= {fa_s, s_sr[N-1:1]};
                    carry <= fa_c;
                    if (cnt == CNT_LAST) begin
                        state <= DONE;
                        sum   <= {fa_s, s_sr[N-1:1]};
                        c_out <= fa_c;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (N=8) using an expected-result queue.
module tb_serial_adder;

    localparam int unsigned N = 8;

    typedef struct packed {
        logic [N-1:0] s;
        logic         c;
    } exp_t;

    logic         clock;
    logic         reset_;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         c_out;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    serial_adder #(.N(N)) dut (
        .clock (clock),
        .reset_(reset_),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Independent reference: plain integer addition.
    task automatic push_exp(input logic [N-1:0] x, input logic [N-1:0] y, input logic ci);
        logic [N:0] t;
        exp_t e;
        t = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, ci};
        e.s = t[N-1:0];
        e.c = t[N];
        sb.push_back(e);
    endtask

    // Drive a one-cycle start; returns at the negedge after the sampling edge.
    task automatic do_start(input logic [N-1:0] x, input logic [N-1:0] y, input logic ci);
        @(negedge clock);
        a = x; b = y; c_in = ci; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Wait (bounded) for done; reports negedges waited and busy samples seen.
    task automatic wait_done(output int n, output int busy_n, output bit ok);
        n = 0; busy_n = 0;
        while (!done && n < 40) begin
            if (busy) busy_n++;
            @(negedge clock);
            n++;
        end
        ok = done;
    endtask

    task automatic pop_and_compare(input string name);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got sum=%h c_out=%b", name, sum, c_out);
        end else begin
            e = sb.pop_front();
            if (sum !== e.s || c_out !== e.c) begin
                errors++;
                $display("FAIL %s: got sum=%h c_out=%b, want sum=%h c_out=%b",
                         name, sum, c_out, e.s, e.c);
            end
        end
    endtask

    task automatic check_ok(input bit ok, input string name);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: timeout waiting for done (got done=0, want 1)", name);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({busy, done, sum, c_out} !== '0) begin
            errors++;
            $display("FAIL reset: got busy=%b done=%b sum=%h c_out=%b, want all 0",
                     busy, done, sum, c_out);
        end
        @(negedge clock);
        reset_ = 1'b1;
    endtask

    task automatic test_zero();
        int n, bn; bit ok;
        push_exp(8'h00, 8'h00, 1'b0);
        do_start(8'h00, 8'h00, 1'b0);
        wait_done(n, bn, ok);
        check_ok(ok, "zero_done");
        checks++;
        if (n !== N || bn !== N) begin
            errors++;
            $display("FAIL zero_latency: got done_after=%0d busy_cycles=%0d, want %0d %0d",
                     n, bn, N, N);
        end
        pop_and_compare("zero_result");
        @(negedge clock);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || sum !== 8'h00) begin
            errors++;
            $display("FAIL zero_pulse: got done=%b busy=%b sum=%h, want 0 0 00", done, busy, sum);
        end
    endtask

    task automatic test_overflow();
        int n, bn; bit ok;
        push_exp(8'hFF, 8'h01, 1'b0);
        do_start(8'hFF, 8'h01, 1'b0);
        // Operand changes after the start edge must not matter.
        a = 8'h12; b = 8'h34; c_in = 1'b1;
        wait_done(n, bn, ok);
        check_ok(ok, "ovf1_done");
        pop_and_compare("ovf1_result");
        push_exp(8'hA5, 8'h5A, 1'b1);
        do_start(8'hA5, 8'h5A, 1'b1);
        wait_done(n, bn, ok);
        check_ok(ok, "ovf2_done");
        pop_and_compare("ovf2_result");
    endtask

    task automatic test_hold();
        int n; bit held;
        push_exp(8'd100, 8'd27, 1'b0);
        do_start(8'd100, 8'd27, 1'b0);
        n = 0; held = 1'b1;
        while (!done && n < 40) begin
            if (sum !== 8'h00 || c_out !== 1'b1) held = 1'b0;
            @(negedge clock);
            n++;
        end
        check_ok(done, "hold_done");
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL hold_during_calc: got changing sum/c_out, want 00/1 held");
        end
        pop_and_compare("hold_result");
    endtask

    task automatic test_ignore_start();
        int n, bn; bit ok;
        push_exp(8'h0F, 8'h01, 1'b0);
        do_start(8'h0F, 8'h01, 1'b0);
        @(negedge clock);
        @(negedge clock);
        a = 8'hF0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL ignore_busy: got busy=%b, want 1", busy);
        end
        wait_done(n, bn, ok);
        check_ok(ok, "ignore_done");
        pop_and_compare("ignore_result");
        @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_no_restart: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int n, bn, gap; bit ok;
        push_exp(8'h33, 8'h11, 1'b0);
        do_start(8'h33, 8'h11, 1'b0);
        a = 8'h01; b = 8'h01; c_in = 1'b0; start = 1'b1;
        push_exp(8'h01, 8'h01, 1'b0);
        wait_done(n, bn, ok);
        check_ok(ok, "b2b_done1");
        pop_and_compare("b2b_result1");
        @(negedge clock);
        start = 1'b0;
        gap = 1;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_reload: got busy=%b done=%b, want 1 0", busy, done);
        end
        wait_done(n, bn, ok);
        gap += n;
        check_ok(ok, "b2b_done2");
        checks++;
        if (gap !== N + 1) begin
            errors++;
            $display("FAIL b2b_gap: got %0d cycles between done pulses, want %0d", gap, N + 1);
        end
        pop_and_compare("b2b_result2");
    endtask

    task automatic test_reset_abort();
        int n, bn, pulses; bit ok;
        do_start(8'hFF, 8'hFF, 1'b0);
        repeat (3) @(negedge clock);
        @(posedge clock);
        #1 reset_ = 1'b0;
        #1;
        checks++;
        if ({busy, done, sum, c_out} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: got busy=%b done=%b sum=%h c_out=%b, want all 0",
                     busy, done, sum, c_out);
        end
        @(negedge clock);
        reset_ = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(negedge clock);
            if (done) pulses++;
        end
        checks++;
        if (pulses !== 0 || sum !== 8'h00) begin
            errors++;
            $display("FAIL abort_no_done: got pulses=%0d sum=%h, want 0 00", pulses, sum);
        end
        push_exp(8'h01, 8'h02, 1'b0);
        do_start(8'h01, 8'h02, 1'b0);
        wait_done(n, bn, ok);
        check_ok(ok, "abort_next_done");
        pop_and_compare("abort_next_result");
    endtask

    initial begin
        reset_ = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
        test_reset();
        test_zero();
        test_overflow();
        test_hold();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
